branch_resolver: RTL and testbench

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_resolver_pkg.sv | 29 ++
 rtl/branch_resolver_if.sv | 27 ++
 rtl/branch_resolver_sat_counter2.sv | 26 ++
 rtl/branch_resolver.sv | 104 ++++++++++
 tb/tb_branch_resolver.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/branch_resolver_pkg.sv
// Shared RV32I types for the branch resolver slice: machine word, the
// 2-bit PHT counter encoding and the saturating step function.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } pht_state_t;

    localparam int PHT_IDX_WIDTH_DEFAULT = 4;

    // One saturating step of a 2-bit predictor counter.
    function automatic pht_state_t pht_step(input pht_state_t cur, input logic up);
        pht_state_t nxt;
        case (cur)
            SNT:     nxt = up ? WNT : SNT;
            WNT:     nxt = up ? WT  : SNT;
            WT:      nxt = up ? ST  : WNT;
            ST:      nxt = up ? ST  : WT;
            default: nxt = WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// EX-stage resolution bus: everything the resolver needs about the branch
// currently in EX, as carried down the pipeline from fetch.
interface branch_resolver_if
    import rv32i_types::*;
#(
    parameter int PHT_IDX_WIDTH = PHT_IDX_WIDTH_DEFAULT
);

    logic                     ex_valid;
    logic                     ex_is_branch;
    logic [PHT_IDX_WIDTH-1:0] ex_pht_idx;
    logic                     ex_pht_prediction;
    logic                     ex_taken;
    rv32i_word                ex_pc_taken;
    rv32i_word                ex_pc_plus4;

    modport master (
        output ex_valid, ex_is_branch, ex_pht_idx, ex_pht_prediction,
               ex_taken, ex_pc_taken, ex_pc_plus4
    );

    modport slave (
        input  ex_valid, ex_is_branch, ex_pht_idx, ex_pht_prediction,
               ex_taken, ex_pc_taken, ex_pc_plus4
    );

endinterface

// File: rtl/branch_resolver_sat_counter2.sv
// One PHT entry: a 2-bit up/down saturating counter, reset to weakly
// not-taken.
module sat_counter2
    import rv32i_types::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up,
    output pht_state_t state
);

    pht_state_t state_r;

    // Counter register: steps toward taken/not-taken when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= WNT;
        end else if (en) begin
            state_r <= pht_step(state_r, up);
        end
    end

    assign state = state_r;

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: trains a bimodal PHT from EX outcomes, raises a one-cycle
// registered flush with the corrected PC on a mispredict, and keeps
// saturating branch / mispredict performance counters.
module branch_resolver
    import rv32i_types::*;
#(
    parameter int PHT_IDX_WIDTH = PHT_IDX_WIDTH_DEFAULT,
    parameter int CNT_WIDTH     = 32
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PHT_IDX_WIDTH-1:0] fetch_idx,
    output logic                     fetch_prediction,
    branch_resolver_if.slave         ex,
    output logic                     flush,
    output rv32i_word                redirect_pc,
    output logic [CNT_WIDTH-1:0]     branch_count,
    output logic [CNT_WIDTH-1:0]     mispredict_count
);

    localparam int ENTRIES = 2 ** PHT_IDX_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 resolve_s;
    logic                 mispredict_s;
    logic [ENTRIES-1:0]   pht_en_s;
    logic [ENTRIES-1:0]   pht_msb_s;
    pht_state_t           pht_state_s [ENTRIES];

    logic                 flush_r;
    rv32i_word            redirect_r;
    rv32i_word            redirect_next_s;
    logic [CNT_WIDTH-1:0] branch_cnt_r;
    logic [CNT_WIDTH-1:0] branch_cnt_next_s;
    logic [CNT_WIDTH-1:0] mispred_cnt_r;
    logic [CNT_WIDTH-1:0] mispred_cnt_next_s;

    // While flushing, the EX slot holds a wrong-path instruction.
    assign resolve_s    = ex.ex_valid & ex.ex_is_branch & ~flush_r;
    // Judged against the prediction made at fetch, not the current table.
    assign mispredict_s = resolve_s & (ex.ex_taken != ex.ex_pht_prediction);

    for (genvar g = 0; g < ENTRIES; g++) begin : g_pht
        assign pht_en_s[g] = resolve_s & (ex.ex_pht_idx == PHT_IDX_WIDTH'(g));

        sat_counter2 u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (pht_en_s[g]),
            .up    (ex.ex_taken),
            .state (pht_state_s[g])
        );

        assign pht_msb_s[g] = pht_state_s[g][1];
    end

    // Stored value only: an update lands in the table on the edge and is
    // visible to fetch from the following cycle.
    assign fetch_prediction = pht_msb_s[fetch_idx];

    // Next-state for the redirect target and the saturating counters.
    always_comb begin
        redirect_next_s    = redirect_r;
        branch_cnt_next_s  = branch_cnt_r;
        mispred_cnt_next_s = mispred_cnt_r;
        if (mispredict_s) begin
            redirect_next_s = ex.ex_taken ? ex.ex_pc_taken : ex.ex_pc_plus4;
        end else begin
            redirect_next_s = redirect_r;
        end
        if (resolve_s && (branch_cnt_r != CNT_MAX)) begin
            branch_cnt_next_s = branch_cnt_r + CNT_ONE;
        end else begin
            branch_cnt_next_s = branch_cnt_r;
        end
        if (mispredict_s && (mispred_cnt_r != CNT_MAX)) begin
            mispred_cnt_next_s = mispred_cnt_r + CNT_ONE;
        end else begin
            mispred_cnt_next_s = mispred_cnt_r;
        end
    end

    // Flush/redirect and performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_r       <= 1'b0;
            redirect_r    <= 32'h0000_0000;
            branch_cnt_r  <= {CNT_WIDTH{1'b0}};
            mispred_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            flush_r       <= mispredict_s;
            redirect_r    <= redirect_next_s;
            branch_cnt_r  <= branch_cnt_next_s;
            mispred_cnt_r <= mispred_cnt_next_s;
        end
    end

    assign flush            = flush_r;
    assign redirect_pc      = redirect_r;
    assign branch_count     = branch_cnt_r;
    assign mispredict_count = mispred_cnt_r;

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: reset checks, a directed vector table, a
// mid-cycle reset sequence, then random traffic against a reference model.
// Counters are built 4 bits wide so saturation is reached quickly.
module tb_branch_resolver;
    import rv32i_types::*;

    localparam int IW   = 4;
    localparam int CW   = 4;
    localparam int NENT = 16;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] fetch_idx;
    logic          fetch_prediction;
    logic          flush;
    rv32i_word     redirect_pc;
    logic [CW-1:0] branch_count;
    logic [CW-1:0] mispredict_count;

    branch_resolver_if #(.PHT_IDX_WIDTH(IW)) ex_bus ();

    branch_resolver #(.PHT_IDX_WIDTH(IW), .CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetch_idx        (fetch_idx),
        .fetch_prediction (fetch_prediction),
        .ex               (ex_bus),
        .flush            (flush),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: predictor strength 0..3 per entry, plain integers.
    int        m_pht [NENT];
    bit        m_flush;
    logic [31:0] m_red;
    int        m_b;
    int        m_m;

    typedef struct {
        logic        v;
        logic        b;
        logic [3:0]  idx;
        logic        pred;
        logic        taken;
        logic [31:0] pct;
        logic [31:0] pc4;
        logic [3:0]  fidx;
        logic        e_pred;
        logic        e_flush;
        logic [31:0] e_red;
        int          e_b;
        int          e_m;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) m_pht[i] = 1;
        m_flush = 1'b0;
        m_red   = 32'h0;
        m_b     = 0;
        m_m     = 0;
    endtask

    // What one rising edge does, given the inputs present before it.
    task automatic model_edge();
        bit res;
        bit mis;
        int k;
        res = ex_bus.ex_valid && ex_bus.ex_is_branch && !m_flush;
        mis = res && (ex_bus.ex_taken != ex_bus.ex_pht_prediction);
        if (res) begin
            k = int'(ex_bus.ex_pht_idx);
            if (ex_bus.ex_taken) m_pht[k] = (m_pht[k] < 3) ? m_pht[k] + 1 : 3;
            else                 m_pht[k] = (m_pht[k] > 0) ? m_pht[k] - 1 : 0;
            m_b = (m_b < CMAX) ? m_b + 1 : CMAX;
        end
        if (mis) begin
            m_m   = (m_m < CMAX) ? m_m + 1 : CMAX;
            m_red = ex_bus.ex_taken ? ex_bus.ex_pc_taken : ex_bus.ex_pc_plus4;
        end
        m_flush = mis;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pred"},  32'(fetch_prediction), 32'(m_pht[int'(fetch_idx)] >= 2));
        chk({tag, ".flush"}, 32'(flush), 32'(m_flush));
        chk({tag, ".redir"}, redirect_pc, m_red);
        chk({tag, ".bcnt"},  32'(branch_count), 32'(m_b));
        chk({tag, ".mcnt"},  32'(mispredict_count), 32'(m_m));
    endtask

    task automatic drive(input logic v, input logic b, input logic [3:0] idx, input logic pred,
                         input logic taken, input logic [31:0] pct, input logic [31:0] pc4,
                         input logic [3:0] fidx);
        ex_bus.ex_valid          = v;
        ex_bus.ex_is_branch      = b;
        ex_bus.ex_pht_idx        = idx;
        ex_bus.ex_pht_prediction = pred;
        ex_bus.ex_taken          = taken;
        ex_bus.ex_pc_taken       = pct;
        ex_bus.ex_pc_plus4       = pc4;
        fetch_idx                = fidx;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        model_reset();

        // Directed table: expectations are the outputs seen before each row's edge.
        tbl[0]  = '{1'b0,1'b0,4'd0,1'b0,1'b0,32'h0,  32'h0,  4'd3, 1'b0,1'b0,32'h000,0,0};
        tbl[1]  = '{1'b1,1'b1,4'd3,1'b0,1'b1,32'h200,32'h34, 4'd3, 1'b0,1'b0,32'h000,0,0};
        tbl[2]  = '{1'b0,1'b0,4'd0,1'b0,1'b0,32'h0,  32'h0,  4'd3, 1'b1,1'b1,32'h200,1,1};
        tbl[3]  = '{1'b1,1'b1,4'd3,1'b0,1'b1,32'h300,32'h38, 4'd3, 1'b1,1'b0,32'h200,1,1};
        tbl[4]  = '{1'b0,1'b0,4'd0,1'b0,1'b0,32'h0,  32'h0,  4'd3, 1'b1,1'b1,32'h300,2,2};
        tbl[5]  = '{1'b1,1'b1,4'd5,1'b0,1'b1,32'h100,32'h44, 4'd5, 1'b0,1'b0,32'h300,2,2};
        tbl[6]  = '{1'b1,1'b1,4'd5,1'b1,1'b0,32'hAAA,32'hBBB,4'd5, 1'b1,1'b1,32'h100,3,3};
        tbl[7]  = '{1'b0,1'b0,4'd0,1'b0,1'b0,32'h0,  32'h0,  4'd5, 1'b1,1'b0,32'h100,3,3};
        tbl[8]  = '{1'b1,1'b1,4'd7,1'b0,1'b0,32'h700,32'h704,4'd7, 1'b0,1'b0,32'h100,3,3};
        tbl[9]  = '{1'b1,1'b1,4'd7,1'b0,1'b0,32'h700,32'h704,4'd7, 1'b0,1'b0,32'h100,4,3};
        tbl[10] = '{1'b1,1'b1,4'd7,1'b0,1'b0,32'h700,32'h704,4'd7, 1'b0,1'b0,32'h100,5,3};
        tbl[11] = '{1'b0,1'b0,4'd0,1'b0,1'b0,32'h0,  32'h0,  4'd7, 1'b0,1'b0,32'h100,6,3};
        tbl[12] = '{1'b1,1'b0,4'd9,1'b1,1'b0,32'h900,32'h904,4'd9, 1'b0,1'b0,32'h100,6,3};
        tbl[13] = '{1'b0,1'b0,4'd0,1'b0,1'b0,32'h0,  32'h0,  4'd9, 1'b0,1'b0,32'h100,6,3};
        tbl[14] = '{1'b1,1'b1,4'd3,1'b1,1'b0,32'h310,32'h314,4'd3, 1'b1,1'b0,32'h100,6,3};
        tbl[15] = '{1'b0,1'b0,4'd0,1'b0,1'b0,32'h0,  32'h0,  4'd3, 1'b1,1'b1,32'h314,7,4};

        // Every index reads not-taken while held in reset.
        #2;
        for (int i = 0; i < NENT; i++) begin
            fetch_idx = 4'(i);
            #1;
            chk("rst_pred", 32'(fetch_prediction), 32'h0);
        end
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_bcnt",  32'(branch_count), 32'h0);
        chk("rst_mcnt",  32'(mispredict_count), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NENT; i++) begin
            fetch_idx = 4'(i);
            #0;
            chk("post_rst_pred", 32'(fetch_prediction), 32'h0);
        end
        check_model("post_rst");

        // Directed table.
        for (int r = 0; r < 16; r++) begin
            drive(tbl[r].v, tbl[r].b, tbl[r].idx, tbl[r].pred, tbl[r].taken,
                  tbl[r].pct, tbl[r].pc4, tbl[r].fidx);
            #2;
            chk($sformatf("row%0d.pred", r),  32'(fetch_prediction), 32'(tbl[r].e_pred));
            chk($sformatf("row%0d.flush", r), 32'(flush), 32'(tbl[r].e_flush));
            chk($sformatf("row%0d.redir", r), redirect_pc, tbl[r].e_red);
            chk($sformatf("row%0d.bcnt", r),  32'(branch_count), 32'(tbl[r].e_b));
            chk($sformatf("row%0d.mcnt", r),  32'(mispredict_count), 32'(tbl[r].e_m));
            model_edge();
            @(posedge clk);
            #1;
        end

        // Mispredict on entry 5, then reset asserted mid-cycle while flushing.
        drive(1'b1, 1'b1, 4'd5, 1'b0, 1'b1, 32'h1E0, 32'h1E4, 4'd5);
        #2;
        model_edge();
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd5);
        chk("pre_abort_flush", 32'(flush), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_flush", 32'(flush), 32'h0);
        chk("abort_redir", redirect_pc, 32'h0);
        chk("abort_bcnt",  32'(branch_count), 32'h0);
        chk("abort_pred5", 32'(fetch_prediction), 32'h0);
        model_reset();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_model("after_abort");
        // One taken update must lift entry 5 from WNT to WT.
        drive(1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 32'h500, 32'h504, 4'd5);
        #2;
        model_edge();
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd5);
        #1;
        chk("entry5_from_wnt", 32'(fetch_prediction), 32'h1);
        check_model("after_abort2");
        @(posedge clk);
        #1;

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) < 7),
                  4'($urandom), 1'($urandom), 1'($urandom),
                  $urandom, $urandom, 4'($urandom));
            #2;
            check_model("rand");
            model_edge();
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
